// File: rtl/instr_mem_responder.sv
// instr_mem_responder
// Memory-side responder for the core's 8-bit program/stack address.
// A request (iREQ/oREADY) performs a registered read of an on-chip
// synchronous memory; the word is pushed one cycle later into a small
// FIFO that drives the oVALID/oDATA/iACK response channel.
//
// A request is only accepted when a response slot is guaranteed:
// in-flight reads plus buffered words (minus any word leaving this
// cycle) must stay below OBUF_DEPTH.
//
// Optional feature, enabled by defining the macro PARITY_EN:
//   - each memory word carries an even-parity bit over the data
//   - iWPINV flips the stored parity bit on a write (error injection)
//   - oPERR flags a parity mismatch on the returned word
module instr_mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              iREQ,
  input  logic [ADDR_W-1:0] iADDR,
  output logic              oREADY,
  output logic              oVALID,
  output logic [DATA_W-1:0] oDATA,
  input  logic              iACK,
  input  logic              iWE,
  input  logic [ADDR_W-1:0] iWADDR,
  input  logic [DATA_W-1:0] iWDATA
`ifdef PARITY_EN
  ,
  input  logic              iWPINV,
  output logic              oPERR
`endif
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int PTR_W     = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CNT_W     = $clog2(OBUF_DEPTH + 1);

`ifdef PARITY_EN
  // Memory word = {parity, data}; buffer entry = {parity error, data}.
  localparam int MEM_W = DATA_W + 1;
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
  localparam int ENT_W = DATA_W;
`endif

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------
  logic [MEM_W-1:0] mem [MEM_DEPTH];
  logic [MEM_W-1:0] wr_word;
  logic [MEM_W-1:0] rd_word;

  logic [ENT_W-1:0] slot [OBUF_DEPTH];
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] head_entry;

  // ------------------------------------------------------------------
  // Control state
  // ------------------------------------------------------------------
  logic             inflight_reg, inflight_next;
  logic [CNT_W-1:0] count_reg,    count_next;
  logic [PTR_W-1:0] wr_ptr_reg,   wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg,   rd_ptr_next;

  logic             valid;
  logic             pop;
  logic             push;
  logic             accept;
  logic             ready;
  logic [CNT_W:0]   occupancy;

  // Advance a buffer pointer, wrapping at OBUF_DEPTH (need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OBUF_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Word as written into memory; parity build adds the (optionally inverted) even-parity bit.
  always_comb begin
`ifdef PARITY_EN
    wr_word = {(^iWDATA) ^ iWPINV, iWDATA};
`else
    wr_word = iWDATA;
`endif
  end

  // Memory write port: unaffected by reset so the program survives it.
  always_ff @(posedge CLK) begin
    if (iWE) begin
      mem[iWADDR] <= wr_word;
    end
  end

  // Registered read port; nonblocking semantics give old data on a same-address write.
  always_ff @(posedge CLK) begin
    if (accept) begin
      rd_word <= mem[iADDR];
    end
  end

  // Entry pushed into the response buffer; parity error is resolved before buffering.
  always_comb begin
`ifdef PARITY_EN
    push_entry = {^rd_word, rd_word[DATA_W-1:0]};
`else
    push_entry = rd_word;
`endif
  end

  // Response buffer storage, written at the tail when the in-flight read lands.
  always_ff @(posedge CLK) begin
    if (push) begin
      slot[wr_ptr_reg] <= push_entry;
    end
  end

  assign head_entry = slot[rd_ptr_reg];

  // Handshake decode and next-state for the in-flight flag, count and pointers.
  always_comb begin
    valid         = (count_reg != '0);
    pop           = valid && iACK;
    push          = inflight_reg;
    // Slots already claimed after this cycle's pop; pop implies count >= 1, so no underflow.
    occupancy     = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg) - (CNT_W + 1)'(pop);
    ready         = RST_N && (occupancy < (CNT_W + 1)'(OBUF_DEPTH));
    accept        = iREQ && ready;

    inflight_next = accept;
    count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_next   = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next   = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
  end

  // Control registers; reset drops every in-flight and buffered response.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      inflight_reg <= inflight_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // Output drive; data is forced to zero while nothing is buffered so reset shows a clean bus.
  always_comb begin
    oREADY = ready;
    oVALID = valid;
    oDATA  = valid ? head_entry[DATA_W-1:0] : '0;
`ifdef PARITY_EN
    oPERR  = valid ? head_entry[DATA_W] : 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Testbench for instr_mem_responder.
// Directed table of vectors for the load/read, backpressure and collision
// scenarios, hand-written reset-mid-operation sequences, an optional parity
// sequence (PARITY_EN), then randomized traffic checked against a
// transaction-level reference model (memory array + response queue).
module tb_instr_mem_responder;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int OD = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          iREQ;
  logic [AW-1:0] iADDR;
  logic          oREADY;
  logic          oVALID;
  logic [DW-1:0] oDATA;
  logic          iACK;
  logic          iWE;
  logic [AW-1:0] iWADDR;
  logic [DW-1:0] iWDATA;
`ifdef PARITY_EN
  logic          iWPINV;
  logic          oPERR;
`endif

  instr_mem_responder #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .OBUF_DEPTH(OD)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .iREQ   (iREQ),
    .iADDR  (iADDR),
    .oREADY (oREADY),
    .oVALID (oVALID),
    .oDATA  (oDATA),
    .iACK   (iACK),
    .iWE    (iWE),
    .iWADDR (iWADDR),
    .iWDATA (iWDATA)
`ifdef PARITY_EN
    ,
    .iWPINV (iWPINV),
    .oPERR  (oPERR)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: memory contents, injected-error flag per word, and
  // the queue of outstanding responses with the cycle each becomes visible.
  typedef struct {
    logic [15:0] data;
    bit          perr;
    int          avail;
  } rsp_t;

  rsp_t        q[$];
  logic [15:0] ref_mem  [256];
  bit          ref_perr [256];
  int          cyc       = 0;
  int          n_vec     = 0;
  int          n_bad     = 0;
  bit          known     = 1'b0;
  bit          after_rst = 1'b0;

  typedef struct {
    bit          req;
    logic [7:0]  addr;
    bit          ack;
    bit          we;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    bit          er;
    bit          ev;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic void add(input bit req, input logic [7:0] addr, input bit ack,
                              input bit we, input logic [7:0] waddr, input logic [15:0] wdata,
                              input bit er, input bit ev, input logic [15:0] ed);
    vec_t v;
    v.req = req; v.addr = addr; v.ack = ack; v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.er = er; v.ev = ev; v.ed = ed;
    tbl.push_back(v);
  endfunction

  // One clock cycle: drive inputs, check outputs against the model at the
  // falling edge, advance the model, then move just past the rising edge.
  task automatic step(input bit rst_n, input bit req, input logic [7:0] addr, input bit ack,
                      input bit we, input logic [7:0] waddr, input logic [15:0] wdata,
                      input bit pinv,
                      output bit got_r, output bit got_v, output logic [15:0] got_d,
                      output bit got_p);
    bit   ev;
    bit   er;
    bit   pop;
    bit   acc;
    rsp_t e;
    RST_N  = rst_n;
    iREQ   = req;
    iADDR  = addr;
    iACK   = ack;
    iWE    = we;
    iWADDR = waddr;
    iWDATA = wdata;
`ifdef PARITY_EN
    iWPINV = pinv;
`endif
    @(negedge CLK);
    got_r = oREADY;
    got_v = oVALID;
    got_d = oDATA;
`ifdef PARITY_EN
    got_p = oPERR;
`else
    got_p = 1'b0;
`endif
    ev  = (q.size() > 0) && (q[0].avail <= cyc);
    pop = ev && ack;
    er  = rst_n && ((q.size() - int'(pop)) < OD);
    acc = req && er;
    chk("ready", oREADY, er);
    if (known) begin
      chk("valid", oVALID, ev);
      if (ev) begin
        chk("data", oDATA, q[0].data);
`ifdef PARITY_EN
        chk("perr", oPERR, q[0].perr);
`endif
      end else if (after_rst) begin
        chk("data_after_rst", oDATA, 16'h0000);
`ifdef PARITY_EN
        chk("perr_after_rst", oPERR, 1'b0);
`endif
      end
    end
    if (pop && rst_n) begin
      $display("rsp cyc=%0d data=%04h", cyc, oDATA);
    end
    if (!rst_n) begin
      q.delete();
      known     = 1'b1;
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (pop) begin
        void'(q.pop_front());
      end
      if (acc) begin
        e.data  = ref_mem[addr];
        e.perr  = ref_perr[addr];
        e.avail = cyc + 2;
        q.push_back(e);
      end
    end
    if (we) begin
      ref_mem[waddr]  = wdata;
      ref_perr[waddr] = pinv;
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit          gr;
    bit          gv;
    bit          gp;
    logic [15:0] gd;

    // Fill every word while held in reset (writes are legal during reset).
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 16'(i * 16'h0101) ^ 16'h5A00, 1'b0,
           gr, gv, gd, gp);
      chk("ready_in_rst", gr, 1'b0);
    end

    // Preload for the directed scenarios.
    add(0, 8'h00, 1, 1, 8'h00, 16'h1111, 1, 0, 16'h0);
    add(0, 8'h00, 1, 1, 8'h01, 16'h2222, 1, 0, 16'h0);
    add(0, 8'h00, 1, 1, 8'h02, 16'h3333, 1, 0, 16'h0);
    add(0, 8'h00, 1, 1, 8'h03, 16'h4444, 1, 0, 16'h0);
    add(0, 8'h00, 1, 1, 8'h10, 16'hA0A0, 1, 0, 16'h0);
    add(0, 8'h00, 1, 1, 8'h11, 16'hA1A1, 1, 0, 16'h0);
    add(0, 8'h00, 1, 1, 8'h12, 16'hA2A2, 1, 0, 16'h0);
    add(0, 8'h00, 1, 1, 8'h20, 16'h0F0F, 1, 0, 16'h0);
    // Load and read: back-to-back requests, continuous acknowledge.
    add(1, 8'h00, 1, 0, 8'h00, 16'h0, 1, 0, 16'h0);
    add(1, 8'h01, 1, 0, 8'h00, 16'h0, 1, 0, 16'h0);
    add(1, 8'h02, 1, 0, 8'h00, 16'h0, 1, 1, 16'h1111);
    add(1, 8'h03, 1, 0, 8'h00, 16'h0, 1, 1, 16'h2222);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 1, 16'h3333);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 1, 16'h4444);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 0, 16'h0);
    // Backpressure: buffer fills, oREADY drops, then drains in order.
    add(1, 8'h10, 0, 0, 8'h00, 16'h0, 1, 0, 16'h0);
    add(1, 8'h11, 0, 0, 8'h00, 16'h0, 1, 0, 16'h0);
    add(1, 8'h12, 0, 0, 8'h00, 16'h0, 0, 1, 16'hA0A0);
    add(1, 8'h12, 0, 0, 8'h00, 16'h0, 0, 1, 16'hA0A0);
    add(1, 8'h12, 1, 0, 8'h00, 16'h0, 1, 1, 16'hA0A0);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 1, 16'hA1A1);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 1, 16'hA2A2);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 0, 16'h0);
    // Read/write collision: old data first, new data on the next read.
    add(1, 8'h20, 1, 1, 8'h20, 16'hBEEF, 1, 0, 16'h0);
    add(1, 8'h20, 1, 0, 8'h00, 16'h0, 1, 0, 16'h0);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 1, 16'h0F0F);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 1, 16'hBEEF);
    add(0, 8'h00, 1, 0, 8'h00, 16'h0, 1, 0, 16'h0);

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].req, tbl[i].addr, tbl[i].ack, tbl[i].we, tbl[i].waddr, tbl[i].wdata,
           1'b0, gr, gv, gd, gp);
      chk("tbl_ready", gr, tbl[i].er);
      chk("tbl_valid", gv, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_data", gd, tbl[i].ed);
      end
      $display("vec %0d req=%0d addr=%02h ack=%0d ready=%0d valid=%0d data=%04h",
               i, tbl[i].req, tbl[i].addr, tbl[i].ack, gr, gv, gd);
    end

    // Reset mid-operation: variant 0 = one buffered + one in flight,
    // variant 1 = two buffered.
    for (int v = 0; v < 2; v++) begin
      step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      if (v == 1) begin
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
        chk("rst_pre_valid", gv, 1'b1);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      chk("rst_ready_low", gr, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      chk("rst_valid", gv, 1'b0);
      chk("rst_data", gd, 16'h0000);
      chk("rst_ready_high", gr, 1'b1);
      step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      chk("rst_no_stale", gv, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      chk("rst_no_stale", gv, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      chk("rst_mem_kept_valid", gv, 1'b1);
      chk("rst_mem_kept_data", gd, 16'h1111);
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
      chk("rst_drained", gv, 1'b0);
    end

`ifdef PARITY_EN
    // Parity: injected error on 0x30, clean word at 0x31.
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 16'h0001, 1'b1, gr, gv, gd, gp);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h31, 16'h0003, 1'b0, gr, gv, gd, gp);
    step(1'b1, 1'b1, 8'h30, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
    step(1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
    chk("par_data0", gd, 16'h0001);
    chk("par_err0", gp, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0, 1'b0, gr, gv, gd, gp);
    chk("par_data1", gd, 16'h0003);
    chk("par_err1", gp, 1'b0);
`endif

    // Randomized traffic against the model; addresses biased to a small
    // window so read/write collisions and reuse are frequent.
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst;
      bit          r_req;
      bit          r_ack;
      bit          r_we;
      bit          r_pinv;
      logic [7:0]  r_addr;
      logic [7:0]  r_waddr;
      logic [15:0] r_wdata;
      r_rst   = ($urandom_range(0, 199) == 0);
      r_req   = ($urandom_range(0, 3) != 0);
      r_ack   = (i % 500 < 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
      r_we    = ($urandom_range(0, 3) == 0);
      r_pinv  = ($urandom_range(0, 1) == 1);
      r_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      r_waddr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      r_wdata = 16'($urandom);
      step(!r_rst, r_req, r_addr, r_ack, r_we, r_waddr, r_wdata, r_pinv, gr, gv, gd, gp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
